cu_pipe_ctrl: RTL and testbench

// Pipelined MIPS control unit: decodes the ID-stage opcode into a control bundle, carries it through
// ID/EX, EX/MEM and MEM/WB registers, and detects load-use hazards. Ext stall and branch flush are

---
 rtl/cu_pipe_ctrl_pkg.sv | 47 ++++
 rtl/cu_pipe_ctrl_decode.sv | 39 +++
 rtl/cu_pipe_ctrl.sv | 95 +++++++++
 tb/tb_cu_pipe_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cu_pipe_ctrl_pkg.sv
// Shared opcode map, ALU-op encodings and the per-stage control bundles
// used by the pipelined control unit.
package cu_pipe_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  localparam logic [2:0] AOP_SUB = 3'b001;  // branch compare
  localparam logic [2:0] AOP_FN  = 3'b010;  // R-type: funct field decides
  localparam logic [2:0] AOP_ADD = 3'b011;  // address calc / addi
  localparam logic [2:0] AOP_SLT = 3'b100;
  localparam logic [2:0] AOP_AND = 3'b101;
  localparam logic [2:0] AOP_OR  = 3'b110;

  typedef struct packed {
    logic       regds;
    logic       alusrc;
    logic [2:0] aop;
  } ex_ctrl_t;

  typedef struct packed {
    logic branch;
    logic bne;
    logic read;
    logic write;
  } mem_ctrl_t;

  typedef struct packed {
    logic mtor;
    logic urw;
  } wb_ctrl_t;

  // Full bundle, MSB first: regds,alusrc,aop,branch,bne,read,write,mtor,urw
  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ctrl_t;

endpackage

// File: rtl/cu_pipe_ctrl_decode.sv
// Combinational opcode decoder: opcode -> control bundle plus illegal flag.
// Unknown opcodes produce an all-zero (bubble) bundle.
module cu_pipe_ctrl_decode
  import cu_pipe_ctrl_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic [OPC_W-1:0] opcode,
  output ctrl_t            ctrl,
  output logic             illegal
);

  // Opcode lookup; default keeps the bundle at zero so X never leaks out
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_W'(OP_R):    begin ctrl.ex = '{1'b1, 1'b0, AOP_FN};  ctrl.wb.urw = 1'b1; end
      OPC_W'(OP_LW):   begin
        ctrl.ex       = '{1'b0, 1'b1, AOP_ADD};
        ctrl.mem.read = 1'b1;
        ctrl.wb       = '{1'b1, 1'b1};
      end
      OPC_W'(OP_SW):   begin ctrl.ex = '{1'b0, 1'b1, AOP_ADD}; ctrl.mem.write = 1'b1; end
      OPC_W'(OP_BEQ):  begin ctrl.ex = '{1'b0, 1'b0, AOP_SUB}; ctrl.mem.branch = 1'b1; end
      OPC_W'(OP_BNE):  begin
        ctrl.ex      = '{1'b0, 1'b0, AOP_SUB};
        ctrl.mem.branch = 1'b1;
        ctrl.mem.bne = 1'b1;
      end
      OPC_W'(OP_ADDI): begin ctrl.ex = '{1'b0, 1'b1, AOP_ADD}; ctrl.wb.urw = 1'b1; end
      OPC_W'(OP_ANDI): begin ctrl.ex = '{1'b0, 1'b1, AOP_AND}; ctrl.wb.urw = 1'b1; end
      OPC_W'(OP_ORI):  begin ctrl.ex = '{1'b0, 1'b1, AOP_OR};  ctrl.wb.urw = 1'b1; end
      OPC_W'(OP_SLTI): begin ctrl.ex = '{1'b0, 1'b1, AOP_SLT}; ctrl.wb.urw = 1'b1; end
      default:         illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cu_pipe_ctrl.sv
// Pipelined control unit: decodes the ID opcode, carries the control bundle
// through ID/EX, EX/MEM and MEM/WB, and flags load-use hazards.
module cu_pipe_ctrl
  import cu_pipe_ctrl_pkg::*;
#(
  parameter int OPC_W  = 6,
  parameter int AOP_W  = 3,
  parameter int RA_W   = 5,
  parameter bit HAZ_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [OPC_W-1:0] id_opcode,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             stall_ext,
  input  logic             flush_id,
  output logic             hazard_stall,
  output logic             ex_valid,
  output logic             ex_regds,
  output logic             ex_alusrc,
  output logic [AOP_W-1:0] ex_aop,
  output logic [RA_W-1:0]  ex_rt,
  output logic             ex_illegal,
  output logic             mem_branch,
  output logic             mem_bne,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_mtor,
  output logic             wb_urw
);

  ctrl_t            dec_ctrl;
  logic             dec_illegal;
  logic             load_bubble;

  // vld_pipe[1]=EX, [2]=MEM, [3]=WB
  logic [3:1]       vld_pipe;
  ctrl_t            ex_q;
  logic [RA_W-1:0]  rt_q;
  logic             ill_q;
  mem_ctrl_t        mem_q;
  wb_ctrl_t         mem_wb_q;
  wb_ctrl_t         wb_q;

  cu_pipe_ctrl_decode #(.OPC_W(OPC_W)) u_dec (
    .opcode  (id_opcode),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // Load in EX whose destination feeds the ID instruction: hold IF/ID one cycle
  assign hazard_stall = HAZ_EN & id_valid & vld_pipe[1] & ex_q.mem.read &
                        ((rt_q == id_rs) | (rt_q == id_rt));

  // Anything that is not a real, legal, unsquashed instruction enters EX as a bubble
  assign load_bubble = ~id_valid | dec_illegal | flush_id | hazard_stall;

  // Stage registers: reset > external stall (hold) > bubble insertion > advance
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      ex_q     <= '0;
      rt_q     <= '0;
      ill_q    <= 1'b0;
      mem_q    <= '0;
      mem_wb_q <= '0;
      wb_q     <= '0;
    end else if (!stall_ext) begin
      vld_pipe <= {vld_pipe[2:1], ~load_bubble};
      ex_q     <= load_bubble ? '0 : dec_ctrl;
      rt_q     <= load_bubble ? '0 : id_rt;
      ill_q    <= id_valid & dec_illegal & ~flush_id & ~hazard_stall;
      mem_q    <= vld_pipe[1] ? ex_q.mem : '0;
      mem_wb_q <= vld_pipe[1] ? ex_q.wb  : '0;
      wb_q     <= vld_pipe[2] ? mem_wb_q : '0;
    end
  end

  // Outputs gated by stage valid so a bubble can never write memory or registers
  assign ex_valid   = vld_pipe[1];
  assign ex_regds   = vld_pipe[1] & ex_q.ex.regds;
  assign ex_alusrc  = vld_pipe[1] & ex_q.ex.alusrc;
  assign ex_aop     = vld_pipe[1] ? AOP_W'(ex_q.ex.aop) : '0;
  assign ex_rt      = rt_q;
  assign ex_illegal = ill_q;
  assign mem_branch = vld_pipe[2] & mem_q.branch;
  assign mem_bne    = vld_pipe[2] & mem_q.bne;
  assign mem_read   = vld_pipe[2] & mem_q.read;
  assign mem_write  = vld_pipe[2] & mem_q.write;
  assign wb_mtor    = vld_pipe[3] & wb_q.mtor;
  assign wb_urw     = vld_pipe[3] & wb_q.urw;

endmodule

// File: tb/tb_cu_pipe_ctrl.sv
// Table-driven bench for cu_pipe_ctrl. Each vector carries its inputs and the
// expected decode of its opcode; a three-entry scoreboard queue (EX, MEM, WB)
// receives the expected entry when the vector is clocked in and is compared
// against the DUT outputs after the edge.
module tb_cu_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst, id_valid, stall_ext, flush_id;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt;

  logic       hazard_stall, ex_valid, ex_regds, ex_alusrc, ex_illegal;
  logic [2:0] ex_aop;
  logic [4:0] ex_rt;
  logic       mem_branch, mem_bne, mem_read, mem_write, wb_mtor, wb_urw;

  logic       h0_hazard, h0_ex_valid, h0_ex_regds, h0_ex_alusrc, h0_ex_illegal;
  logic [2:0] h0_ex_aop;
  logic [4:0] h0_ex_rt;
  logic       h0_mem_branch, h0_mem_bne, h0_mem_read, h0_mem_write, h0_wb_mtor, h0_wb_urw;

  always #5 clk = ~clk;

  cu_pipe_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .stall_ext(stall_ext), .flush_id(flush_id),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_regds(ex_regds),
    .ex_alusrc(ex_alusrc), .ex_aop(ex_aop), .ex_rt(ex_rt), .ex_illegal(ex_illegal),
    .mem_branch(mem_branch), .mem_bne(mem_bne), .mem_read(mem_read),
    .mem_write(mem_write), .wb_mtor(wb_mtor), .wb_urw(wb_urw)
  );

  cu_pipe_ctrl #(.HAZ_EN(1'b0)) dut_nohaz (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .stall_ext(stall_ext), .flush_id(flush_id),
    .hazard_stall(h0_hazard), .ex_valid(h0_ex_valid), .ex_regds(h0_ex_regds),
    .ex_alusrc(h0_ex_alusrc), .ex_aop(h0_ex_aop), .ex_rt(h0_ex_rt),
    .ex_illegal(h0_ex_illegal), .mem_branch(h0_mem_branch), .mem_bne(h0_mem_bne),
    .mem_read(h0_mem_read), .mem_write(h0_mem_write), .wb_mtor(h0_wb_mtor),
    .wb_urw(h0_wb_urw)
  );

  // Expected bundles: {regds,alusrc,aop[2:0],branch,bne,read,write,mtor,urw}
  localparam logic [10:0] C_R    = 11'b1_0_010_0000_01;
  localparam logic [10:0] C_LW   = 11'b0_1_011_0010_11;
  localparam logic [10:0] C_SW   = 11'b0_1_011_0001_00;
  localparam logic [10:0] C_BEQ  = 11'b0_0_001_1000_00;
  localparam logic [10:0] C_BNE  = 11'b0_0_001_1100_00;
  localparam logic [10:0] C_ADDI = 11'b0_1_011_0000_01;
  localparam logic [10:0] C_ANDI = 11'b0_1_101_0000_01;
  localparam logic [10:0] C_ORI  = 11'b0_1_110_0000_01;
  localparam logic [10:0] C_SLTI = 11'b0_1_100_0000_01;
  localparam logic [10:0] C_NONE = 11'b0;

  typedef struct {
    logic        rst, v;
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic        st, fl;
    logic [10:0] c;
    logic        ill;
  } vec_t;

  typedef struct {
    logic        v;
    logic [10:0] c;
    logic [4:0]  rt;
    logic        ill;
  } stg_t;

  vec_t tbl[$];
  stg_t sb[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   step     = 0;
  bit   init     = 1'b0;

  task automatic add(input logic r, input logic v, input logic [5:0] op,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic st, input logic fl,
                     input logic [10:0] c, input logic ill);
    vec_t x;
    x.rst = r; x.v = v; x.op = op; x.rs = rs; x.rt = rt;
    x.st = st; x.fl = fl; x.c = c; x.ill = ill;
    tbl.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) add(0, 0, 6'b100011, 5'd0, 5'd0, 0, 0, C_NONE, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s step %0d: got %h want %h", name, step, act, exp);
  endtask

  initial begin
    vec_t   x;
    stg_t   n, bub;
    logic   exp_h, bubl;
    logic [17:0] act_o, exp_o;

    bub.v = 0; bub.c = '0; bub.rt = '0; bub.ill = 0;

    // reset held with a live LW in ID, then the first real LW
    add(1, 1, 6'b100011, 5'd1, 5'd2, 0, 0, C_LW, 0);
    add(1, 1, 6'b100011, 5'd1, 5'd2, 0, 0, C_LW, 0);
    add(0, 1, 6'b100011, 5'd1, 5'd2, 0, 0, C_LW, 0);
    // mixed stream
    add(0, 1, 6'b000000, 5'd3,  5'd4,  0, 0, C_R, 0);
    add(0, 1, 6'b100011, 5'd5,  5'd9,  0, 0, C_LW, 0);
    add(0, 1, 6'b101011, 5'd10, 5'd11, 0, 0, C_SW, 0);
    add(0, 1, 6'b000100, 5'd1,  5'd2,  0, 0, C_BEQ, 0);
    add(0, 1, 6'b001000, 5'd12, 5'd13, 0, 0, C_ADDI, 0);
    add(0, 1, 6'b000101, 5'd14, 5'd15, 0, 0, C_BNE, 0);
    idle(3);
    // load-use on rs, then on rt; the dependent instr is held one cycle in ID
    add(0, 1, 6'b100011, 5'd1, 5'd8, 0, 0, C_LW, 0);
    add(0, 1, 6'b000000, 5'd8, 5'd3, 0, 0, C_R, 0);
    add(0, 1, 6'b000000, 5'd8, 5'd3, 0, 0, C_R, 0);
    idle(1);
    add(0, 1, 6'b100011, 5'd2, 5'd8, 0, 0, C_LW, 0);
    add(0, 1, 6'b000000, 5'd4, 5'd8, 0, 0, C_R, 0);
    add(0, 1, 6'b000000, 5'd4, 5'd8, 0, 0, C_R, 0);
    idle(3);
    // external stall for three cycles mid-stream
    add(0, 1, 6'b000000, 5'd1, 5'd2, 0, 0, C_R, 0);
    add(0, 1, 6'b001100, 5'd3, 5'd4, 0, 0, C_ANDI, 0);
    add(0, 1, 6'b001101, 5'd5, 5'd6, 1, 0, C_ORI, 0);
    add(0, 1, 6'b001101, 5'd5, 5'd6, 1, 0, C_ORI, 0);
    add(0, 1, 6'b001101, 5'd5, 5'd6, 1, 0, C_ORI, 0);
    add(0, 1, 6'b001101, 5'd5, 5'd6, 0, 0, C_ORI, 0);
    add(0, 1, 6'b001010, 5'd7, 5'd9, 0, 0, C_SLTI, 0);
    idle(3);
    // stall on top of a pending load-use: hazard stays visible from held state
    add(0, 1, 6'b100011, 5'd1, 5'd7, 0, 0, C_LW, 0);
    add(0, 1, 6'b000000, 5'd7, 5'd1, 1, 0, C_R, 0);
    add(0, 1, 6'b000000, 5'd7, 5'd1, 1, 0, C_R, 0);
    add(0, 1, 6'b000000, 5'd7, 5'd1, 0, 0, C_R, 0);
    add(0, 1, 6'b000000, 5'd7, 5'd1, 0, 0, C_R, 0);
    idle(3);
    // branch flush squashes a store in ID
    add(0, 1, 6'b000000, 5'd1, 5'd2, 0, 0, C_R, 0);
    add(0, 1, 6'b101011, 5'd3, 5'd4, 0, 1, C_SW, 0);
    idle(3);
    // illegal opcodes: live, invalid, and flushed
    add(0, 1, 6'b111111, 5'd1, 5'd2, 0, 0, C_NONE, 1);
    idle(1);
    add(0, 0, 6'b111111, 5'd1, 5'd2, 0, 0, C_NONE, 1);
    add(0, 1, 6'b010000, 5'd1, 5'd2, 0, 1, C_NONE, 1);
    idle(2);
    // reset mid-stream discards in-flight instructions
    add(0, 1, 6'b100011, 5'd1, 5'd2, 0, 0, C_LW, 0);
    add(0, 1, 6'b101011, 5'd3, 5'd4, 0, 0, C_SW, 0);
    add(1, 1, 6'b000000, 5'd5, 5'd6, 0, 0, C_R, 0);
    idle(3);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      step = i;
      x = tbl[i];
      rst = x.rst; id_valid = x.v; id_opcode = x.op; id_rs = x.rs; id_rt = x.rt;
      stall_ext = x.st; flush_id = x.fl;
      #1;
      exp_h = 1'b0;
      if (init) begin
        exp_h = x.v & sb[0].v & sb[0].c[3] & ((sb[0].rt == x.rs) | (sb[0].rt == x.rt));
        chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, exp_h});
      end
      chk("hazard_off", {31'd0, h0_hazard}, 32'd0);

      @(posedge clk);
      if (x.rst) begin
        sb.delete();
        for (int k = 0; k < 3; k++) sb.push_back(bub);
        init = 1'b1;
      end else if (!x.st) begin
        bubl  = x.fl | exp_h | ~x.v | x.ill;
        n.v   = ~bubl;
        n.c   = bubl ? 11'd0 : x.c;
        n.rt  = bubl ? 5'd0 : x.rt;
        n.ill = x.v & x.ill & ~x.fl & ~exp_h;
        sb.push_front(n);
        void'(sb.pop_back());
      end

      @(negedge clk);
      if (init) begin
        act_o = {ex_valid, ex_regds, ex_alusrc, ex_aop, ex_rt, ex_illegal,
                 mem_branch, mem_bne, mem_read, mem_write, wb_mtor, wb_urw};
        exp_o = {sb[0].v, sb[0].c[10:6], sb[0].rt, sb[0].ill, sb[1].c[5:2], sb[2].c[1:0]};
        chk("stage_outputs", {14'd0, act_o}, {14'd0, exp_o});
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
